// File: rtl/raster_pkg.sv
// Shared types, widths and bbox helpers for the triangle rasterizer.
package raster_pkg;

   localparam int COORD_W = 10;
   localparam int DIFF_W  = COORD_W + 1;
   localparam int EDGE_W  = 24;

   typedef logic [COORD_W-1:0]       screen_coord_t;
   typedef screen_coord_t [1:0]      vertex_t;      // [1] = x, [0] = y
   typedef vertex_t [2:0]            triangle_t;
   typedef logic signed [EDGE_W-1:0] edge_t;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SCAN,
      FINISH
   } state_t;

   function automatic screen_coord_t min3(input screen_coord_t a, input screen_coord_t b,
                                          input screen_coord_t c);
      screen_coord_t m;
      m = (a < b) ? a : b;
      return (m < c) ? m : c;
   endfunction

   function automatic screen_coord_t max3(input screen_coord_t a, input screen_coord_t b,
                                          input screen_coord_t c);
      screen_coord_t m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/edge_eval.sv
// One edge function E(x,y) = (x-xi)*(yj-yi) - (y-yi)*(xj-xi), fully combinational.
module edge_eval
   import raster_pkg::*;
(
   input  screen_coord_t px_i,
   input  screen_coord_t py_i,
   input  screen_coord_t xi_i,
   input  screen_coord_t yi_i,
   input  screen_coord_t xj_i,
   input  screen_coord_t yj_i,
   output edge_t         e_o
);

   logic signed [DIFF_W-1:0] dx, dy, ex, ey;
   edge_t dx_w, dy_w, ex_w, ey_w;

   // Zero-extend to 11 bits so every difference of two 10-bit coords is exact.
   assign dx = $signed({1'b0, px_i}) - $signed({1'b0, xi_i});
   assign dy = $signed({1'b0, py_i}) - $signed({1'b0, yi_i});
   assign ex = $signed({1'b0, xj_i}) - $signed({1'b0, xi_i});
   assign ey = $signed({1'b0, yj_i}) - $signed({1'b0, yi_i});

   assign dx_w = edge_t'(dx);
   assign dy_w = edge_t'(dy);
   assign ex_w = edge_t'(ex);
   assign ey_w = edge_t'(ey);

   assign e_o = (dx_w * ey_w) - (dy_w * ex_w);

endmodule

// File: rtl/triangle_rasterizer.sv
// Bounding-box scan rasterizer: emits every covered pixel of one triangle in raster order.
//   state  | meaning
//   IDLE   | waiting for a triangle, tri_ready high
//   SETUP  | bbox, clamp and area from registered vertices
//   SCAN   | one bbox candidate per cycle, stalls on pix_ready
//   FINISH | one-cycle done pulse
module triangle_rasterizer
   import raster_pkg::*;
#(
   parameter screen_coord_t H_RES = 10'd100,
   parameter screen_coord_t V_RES = 10'd100
)
(
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 tri_valid,
   output logic                 tri_ready,
   input  logic [2:0][1:0][9:0] proj_triangle,
   output logic                 pix_valid,
   input  logic                 pix_ready,
   output logic [9:0]           pix_x,
   output logic [9:0]           pix_y,
   output logic                 done
);

   localparam screen_coord_t X_LAST = H_RES - 10'd1;
   localparam screen_coord_t Y_LAST = V_RES - 10'd1;

   state_t        state_q, state_d;
   triangle_t     tri_q, tri_d;
   screen_coord_t x_q, x_d, y_q, y_d;
   screen_coord_t min_x_q, min_x_d, max_x_q, max_x_d, max_y_q, max_y_d;

   screen_coord_t ev_x, ev_y;
   screen_coord_t bb_min_x, bb_max_x, bb_min_y, bb_max_y;
   edge_t         e0, e1, e2;
   logic          all_pos, all_neg, covered, empty_tri;

   // During SETUP edge 0 is evaluated at vertex 2, giving the signed area.
   assign ev_x = (state_q == SETUP) ? tri_q[2][1] : x_q;
   assign ev_y = (state_q == SETUP) ? tri_q[2][0] : y_q;

   edge_eval u_e0 (
      .px_i (ev_x),        .py_i (ev_y),
      .xi_i (tri_q[0][1]), .yi_i (tri_q[0][0]),
      .xj_i (tri_q[1][1]), .yj_i (tri_q[1][0]),
      .e_o  (e0)
   );

   edge_eval u_e1 (
      .px_i (ev_x),        .py_i (ev_y),
      .xi_i (tri_q[1][1]), .yi_i (tri_q[1][0]),
      .xj_i (tri_q[2][1]), .yj_i (tri_q[2][0]),
      .e_o  (e1)
   );

   edge_eval u_e2 (
      .px_i (ev_x),        .py_i (ev_y),
      .xi_i (tri_q[2][1]), .yi_i (tri_q[2][0]),
      .xj_i (tri_q[0][1]), .yj_i (tri_q[0][0]),
      .e_o  (e2)
   );

   assign bb_min_x = min3(tri_q[0][1], tri_q[1][1], tri_q[2][1]);
   assign bb_max_x = max3(tri_q[0][1], tri_q[1][1], tri_q[2][1]);
   assign bb_min_y = min3(tri_q[0][0], tri_q[1][0], tri_q[2][0]);
   assign bb_max_y = max3(tri_q[0][0], tri_q[1][0], tri_q[2][0]);

   // Either winding is accepted; zero on an edge counts as inside.
   assign all_pos   = !e0[EDGE_W-1] && !e1[EDGE_W-1] && !e2[EDGE_W-1];
   assign all_neg   = (e0[EDGE_W-1] || (e0 == '0)) && (e1[EDGE_W-1] || (e1 == '0))
                   && (e2[EDGE_W-1] || (e2 == '0));
   assign covered   = all_pos || all_neg;
   assign empty_tri = (e0 == '0) || (bb_min_x >= H_RES) || (bb_min_y >= V_RES);

   always_comb begin
      state_d = state_q;
      tri_d   = tri_q;
      x_d     = x_q;
      y_d     = y_q;
      min_x_d = min_x_q;
      max_x_d = max_x_q;
      max_y_d = max_y_q;
      unique case (state_q)
         IDLE: begin
            if (tri_valid) begin
               tri_d   = proj_triangle;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (empty_tri) begin
               state_d = FINISH;
            end else begin
               min_x_d = bb_min_x;
               max_x_d = (bb_max_x > X_LAST) ? X_LAST : bb_max_x;
               max_y_d = (bb_max_y > Y_LAST) ? Y_LAST : bb_max_y;
               x_d     = bb_min_x;
               y_d     = bb_min_y;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (!covered || pix_ready) begin
               if (x_q == max_x_q) begin
                  if (y_q == max_y_q) begin
                     state_d = FINISH;
                  end else begin
                     x_d = min_x_q;
                     y_d = y_q + 10'd1;
                  end
               end else begin
                  x_d = x_q + 10'd1;
               end
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         tri_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         min_x_q <= '0;
         max_x_q <= '0;
         max_y_q <= '0;
      end else begin
         state_q <= state_d;
         tri_q   <= tri_d;
         x_q     <= x_d;
         y_q     <= y_d;
         min_x_q <= min_x_d;
         max_x_q <= max_x_d;
         max_y_q <= max_y_d;
      end
   end

   assign tri_ready = (state_q == IDLE) && !Reset;
   assign pix_valid = (state_q == SCAN) && covered && !Reset;
   assign done      = (state_q == FINISH) && !Reset;
   assign pix_x     = Reset ? '0 : x_q;
   assign pix_y     = Reset ? '0 : y_q;

endmodule

// File: doc/triangle_rasterizer.md
TRIANGLE_RASTERIZER -- requirements
Module: triangle_rasterizer

Interface
REQ-001 The block SHALL have parameter H_RES, default 10'd100, meaning screen width in pixels.
REQ-002 The block SHALL have parameter V_RES, default 10'd100, meaning screen height in pixels.
REQ-003 Port Clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port Reset, input, 1, synchronous active-high reset.
REQ-005 Port tri_valid, input, 1, upstream projected triangle valid.
REQ-006 Port tri_ready, output, 1, block can accept a triangle.
REQ-007 Port proj_triangle, input, [2:0][1:0][9:0], three vertices; [i][1] is x, [i][0] is y, unsigned screen pixels.
REQ-008 Port pix_valid, output, 1, pix_x/pix_y hold a covered pixel.
REQ-009 Port pix_ready, input, 1, downstream accepts the pixel.
REQ-010 Port pix_x, output, 10, covered pixel column.
REQ-011 Port pix_y, output, 10, covered pixel row.
REQ-012 Port done, output, 1, one-cycle pulse when the current triangle is fully rasterized.

Function
REQ-013 The FSM SHALL have states IDLE, SETUP, SCAN and FINISH.
REQ-014 tri_ready SHALL be 1 only in IDLE; a triangle is accepted when tri_valid && tri_ready, and the vertices are registered on that edge.
REQ-015 In SETUP (1 cycle), the block SHALL compute bbox min/max of the vertex x and y values, clamp max to H_RES-1/V_RES-1, and compute signed area A = E0 evaluated at vertex 2.
REQ-016 Edge function Ei(x,y) = (x-xi)*(yj-yi) - (y-yi)*(xj-xi), j=(i+1) mod 3, SHALL use 24-bit signed arithmetic with 11-bit signed operand differences; no truncation is permitted.
REQ-017 Pixel (x,y) SHALL be covered iff all three Ei >= 0, or all three Ei <= 0; both windings are accepted and samples lying on an edge count as covered.
REQ-018 If A == 0, or min x >= H_RES, or min y >= V_RES, SETUP SHALL go directly to FINISH and no pixel is emitted.
REQ-019 SCAN SHALL visit the bbox in raster order, y outer and x inner, ascending, at one candidate per cycle.
REQ-020 Uncovered candidates SHALL advance without asserting pix_valid.
REQ-021 A covered candidate SHALL assert pix_valid with its coordinates, and the scan SHALL advance only on pix_valid && pix_ready.
REQ-022 While pix_valid && !pix_ready, pix_x and pix_y SHALL remain stable.
REQ-023 The first candidate SHALL be presented 2 cycles after acceptance.
REQ-024 After the last bbox candidate is resolved (covered-and-accepted, or uncovered), the FSM SHALL enter FINISH, assert done for exactly 1 cycle, and return to IDLE.
REQ-025 tri_ready SHALL rise on the cycle after done.
REQ-026 tri_valid changes outside IDLE SHALL be ignored; proj_triangle SHALL only be sampled on acceptance.
REQ-027 Each covered pixel SHALL be emitted exactly once, with no duplicates and no omissions.

Reset
REQ-028 While Reset is 1, the block SHALL force state=IDLE, pix_valid=0, done=0, tri_ready=0, and pix_x=pix_y=0.
REQ-029 tri_ready SHALL be 1 in the first cycle after Reset deasserts.
REQ-030 Reset during SETUP or SCAN SHALL abandon the triangle with no done pulse; the following triangle SHALL rasterize correctly.

Structure
REQ-031 Shared package raster_pkg SHALL hold typedefs screen_coord_t (10-bit), vertex_t, triangle_t, edge_t (signed 24-bit), the state enum, and the edge-function widths.
REQ-032 One sub-module, edge_eval, SHALL compute a single Ei combinationally and be instantiated three times.

Verification
REQ-033 Right triangle (0,0),(3,0),(0,3) -> 10 pixels in order: y0 x0..3, y1 x0..2, y2 x0..1, y3 x0; then done.
REQ-034 Reversed winding (0,0),(0,3),(3,0) -> the same 10 pixels in the same order.
REQ-035 Collinear triangle (0,0),(5,5),(10,10) -> zero pixel beats; done asserted 2 cycles after acceptance.
REQ-036 Clipping triangle (90,90),(150,90),(90,150) with default H_RES/V_RES -> 100 pixels, x,y in 90..99, none >= 100.
REQ-037 Backpressure: pix_ready low for 5 cycles mid-stream on REQ-033 -> outputs stable, and the 10-pixel sequence is unchanged.
REQ-038 Reset pulsed mid-SCAN -> pix_valid=0 next cycle, no done, tri_ready=1 after release; next triangle per REQ-033 passes.
